// File: rtl/data_island_scheduler.sv
// data_island_scheduler
//   Schedules HDMI data islands inside horizontal blanking. After a
//   blankStart pulse (with enough blanking) it waits LEAD_DELAY control
//   characters, emits an 8-character preamble and a 2-character leading
//   guard band. It then sends up to MAX_PACKETS 32-character packets,
//   one requester per packet, and closes with a 2-character trailing guard
//   band.
//
//   Arbitration: fixed priority by default (req[0] highest). Defining
//   DATA_ISLAND_ROUND_ROBIN_EN selects round-robin arbitration, which starts
//   after the last grantee. The pointer is kept across islands.
//
// Ports
//   pixelClock          sole clock, rising edge
//   resetN              asynchronous active-low reset
//   blankStart          1-cycle pulse at start of horizontal blanking
//   blankLength[11:0]   blanking length in characters, sampled with blankStart
//   req[2:0]            per-requester packet request level, held until acked
//   grant[2:0]          one-hot owner of the current packet slot
//   ack[2:0]            pulse on the last character of the granted packet
//   isFirstPacketClock  pulse one cycle before each packet's first character
//   dataIslandActive    high from first preamble to last trailing-guard char
//   phase[1:0]          0 control, 1 preamble, 2 guard band, 3 packet
module data_island_scheduler #(
  parameter int unsigned LEAD_DELAY  = 42,
  parameter int unsigned MAX_PACKETS = 4
) (
  input  logic        pixelClock,
  input  logic        resetN,
  input  logic        blankStart,
  input  logic [11:0] blankLength,
  input  logic [2:0]  req,
  output logic [2:0]  grant,
  output logic [2:0]  ack,
  output logic        isFirstPacketClock,
  output logic        dataIslandActive,
  output logic [1:0]  phase
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT     = 3'd1;
  localparam logic [2:0] PREAMBLE = 3'd2;
  localparam logic [2:0] LGUARD   = 3'd3;
  localparam logic [2:0] PACKET   = 3'd4;
  localparam logic [2:0] TGUARD   = 3'd5;

  localparam logic [1:0] PH_CONTROL  = 2'd0;
  localparam logic [1:0] PH_PREAMBLE = 2'd1;
  localparam logic [1:0] PH_GUARD    = 2'd2;
  localparam logic [1:0] PH_PACKET   = 2'd3;

  localparam int unsigned MIN_BLANK = LEAD_DELAY + 44;
  localparam logic [11:0] LEAD_LAST = 12'(LEAD_DELAY - 1);

  logic [2:0]  state;
  logic [11:0] cnt;            // cycles remaining in the current state, minus one
  logic [11:0] latchedLength;
  logic [4:0]  pktCount;       // packets started in this island
  logic [2:0]  pendGrant;
  logic        pendValid;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
  logic [1:0]  rrPtr;          // highest-priority requester for the next pick
  logic [5:0]  candDouble;
  logic [2:0]  candRotated;
  logic [2:0]  pickRotated;
  logic [5:0]  pickDouble;
`endif

  logic [2:0]  candidates;
  logic [2:0]  winner;
  int unsigned k;
  logic        budgetOk;
  logic        countOk;
  logic        arbValid;
  logic        arbEdge;

  // Outputs are registered, so arbitration is resolved on the edge that
  // enters the arbitration cycle (last LGUARD / last PACKET character).
  // This lets isFirstPacketClock and ack appear during that cycle. The
  // resulting grant is loaded on the following edge.
  always_comb begin
    candidates = req & ((state == PACKET) ? ~grant : 3'b111);
    k          = (state == PACKET) ? {27'd0, pktCount} : 32'd0;
    budgetOk   = (LEAD_DELAY + 32'd46 + 32'd32 * k) <= {20'd0, latchedLength};
    countOk    = k < MAX_PACKETS;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
    // Rotate so rrPtr sits at bit 0, take the lowest set bit, rotate back.
    candDouble  = {candidates, candidates} >> rrPtr;
    candRotated = candDouble[2:0];
    pickRotated = candRotated & (~candRotated + 3'd1);
    pickDouble  = {pickRotated, pickRotated} << rrPtr;
    winner      = pickDouble[5:3];
`else
    winner      = candidates & (~candidates + 3'd1);
`endif
    arbValid   = (winner != 3'b000) && budgetOk && countOk;
    arbEdge    = ((state == LGUARD) || (state == PACKET)) && (cnt == 12'd1);
  end

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state              <= IDLE;
      cnt                <= '0;
      latchedLength      <= '0;
      pktCount           <= '0;
      pendGrant          <= '0;
      pendValid          <= 1'b0;
      grant              <= '0;
      ack                <= '0;
      isFirstPacketClock <= 1'b0;
      dataIslandActive   <= 1'b0;
      phase              <= PH_CONTROL;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
      rrPtr              <= 2'd0;
`endif
    end else begin
      ack                <= '0;
      isFirstPacketClock <= 1'b0;
      if (cnt != '0) cnt <= cnt - 12'd1;

      if (arbEdge) begin
        pendGrant          <= arbValid ? winner : 3'b000;
        pendValid          <= arbValid;
        isFirstPacketClock <= arbValid;
      end

      if ((state == PACKET) && (cnt == 12'd1)) ack <= grant;

      case (state)
        IDLE: begin
          if (blankStart && ({20'd0, blankLength} >= MIN_BLANK)) begin
            state         <= WAIT;
            cnt           <= LEAD_LAST;
            latchedLength <= blankLength;
            pktCount      <= '0;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (req != 3'b000) begin
              state            <= PREAMBLE;
              cnt              <= 12'd7;
              phase            <= PH_PREAMBLE;
              dataIslandActive <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        PREAMBLE: begin
          if (cnt == '0) begin
            state <= LGUARD;
            cnt   <= 12'd1;
            phase <= PH_GUARD;
          end
        end
        LGUARD, PACKET: begin
          if (cnt == '0) begin
            if (pendValid) begin
              state    <= PACKET;
              cnt      <= 12'd31;
              grant    <= pendGrant;
              pktCount <= pktCount + 5'd1;
              phase    <= PH_PACKET;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
              rrPtr    <= pendGrant[0] ? 2'd1 : (pendGrant[1] ? 2'd2 : 2'd0);
`endif
            end else begin
              state <= TGUARD;
              cnt   <= 12'd1;
              grant <= '0;
              phase <= PH_GUARD;
            end
          end
        end
        TGUARD: begin
          if (cnt == '0) begin
            state            <= IDLE;
            phase            <= PH_CONTROL;
            dataIslandActive <= 1'b0;
          end
        end
        default: begin
          state            <= IDLE;
          grant            <= '0;
          phase            <= PH_CONTROL;
          dataIslandActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_island_scheduler.sv
module tb_data_island_scheduler;

  localparam int unsigned LEAD = 42;
  localparam int unsigned MAXP = 4;

  logic        pixelClock = 1'b0;
  logic        resetN;
  logic        blankStart;
  logic [11:0] blankLength;
  logic [2:0]  req;
  logic [2:0]  grant;
  logic [2:0]  ack;
  logic        isFirstPacketClock;
  logic        dataIslandActive;
  logic [1:0]  phase;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Expected {grant, ack, isFirst, active, phase} per cycle, index = cycles after blankStart.
  logic [9:0]  expv [0:399];
  int unsigned lineEnd;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
  int unsigned modelPtr = 0;
`endif

  data_island_scheduler #(.LEAD_DELAY(LEAD), .MAX_PACKETS(MAXP)) dut (
    .pixelClock        (pixelClock),
    .resetN            (resetN),
    .blankStart        (blankStart),
    .blankLength       (blankLength),
    .req               (req),
    .grant             (grant),
    .ack               (ack),
    .isFirstPacketClock(isFirstPacketClock),
    .dataIslandActive  (dataIslandActive),
    .phase             (phase)
  );

  always #5 pixelClock = ~pixelClock;

  function automatic int unsigned pick(input logic [2:0] cand);
    int unsigned first = 0;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
    first = modelPtr;
`endif
    for (int unsigned i = 0; i < 3; i++) begin
      if (cand[(first + i) % 3]) return (first + i) % 3;
    end
    return 0;
  endfunction

  // Reference schedule: island timeline plus one packet per pending
  // requester, limited by packet count and blanking budget.
  task automatic build_model(input logic [11:0] len, input logic [2:0] r0);
    int unsigned L = {20'd0, len};
    int unsigned kk = 0;
    int unsigned st;
    int unsigned w;
    logic [2:0]  pend = r0;
    logic [2:0]  g;
    for (int i = 0; i < 400; i++) expv[i] = '0;
    if (L < LEAD + 44 || r0 == 3'b000) begin
      lineEnd = LEAD + 8;
      return;
    end
    for (int unsigned t = LEAD + 1; t <= LEAD + 8; t++) expv[t] = {6'b0, 1'b0, 1'b1, 2'd1};
    expv[LEAD + 9]  = {6'b0, 1'b0, 1'b1, 2'd2};
    expv[LEAD + 10] = {6'b0, 1'b0, 1'b1, 2'd2};
    while (pend != 3'b000 && kk < MAXP && LEAD + 12 + 32 * (kk + 1) + 2 <= L) begin
      w  = pick(pend);
      g  = '0;
      g[w] = 1'b1;
      st = LEAD + 11 + 32 * kk;
      expv[st - 1][3] = 1'b1;
      for (int unsigned c = st; c < st + 32; c++) expv[c] = {g, 3'b000, 1'b0, 1'b1, 2'd3};
      expv[st + 31][6:4] = g;
      pend = pend & ~g;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
      modelPtr = (w + 1) % 3;
`endif
      kk++;
    end
    expv[LEAD + 11 + 32 * kk] = {6'b0, 1'b0, 1'b1, 2'd2};
    expv[LEAD + 12 + 32 * kk] = {6'b0, 1'b0, 1'b1, 2'd2};
    lineEnd = LEAD + 13 + 32 * kk;
  endtask

  // Drives one blanking line and checks every cycle up to the first idle
  // cycle. Requesters drop their bit once acked. midPulse injects a stray
  // blankStart; abortAt pulls resetN low in that cycle.
  task automatic run_line(input logic [11:0] len, input logic [2:0] newReq,
                          input int unsigned midPulseIn, input int unsigned abortAt);
    logic [9:0]  got;
    int unsigned midPulse = midPulseIn;
    req = req | newReq;
    build_model(len, req);
    if (midPulse >= lineEnd) midPulse = 0;
    blankStart  = 1'b1;
    blankLength = len;
    @(posedge pixelClock); #1;
    blankStart  = 1'b0;
    blankLength = 12'($urandom);
    for (int unsigned t = 1; t <= lineEnd; t++) begin
      got = {grant, ack, isFirstPacketClock, dataIslandActive, phase};
      vectors++;
      if (got !== expv[t]) begin
        miscompares++;
        $display("FAIL line(len=%0d) T%0d: got grant=%b ack=%b first=%b active=%b phase=%0d, want %b",
                 len, t, grant, ack, isFirstPacketClock, dataIslandActive, phase, expv[t]);
      end
      if (t == abortAt) begin
        #2 resetN = 1'b0;
        #1;
        got = {grant, ack, isFirstPacketClock, dataIslandActive, phase};
        vectors++;
        if (got !== 10'b0) begin
          miscompares++;
          $display("FAIL async_reset T%0d: got %b, want 0000000000", t, got);
        end
        #1 resetN = 1'b1;
`ifdef DATA_ISLAND_ROUND_ROBIN_EN
        modelPtr = 0;
`endif
        @(posedge pixelClock); #1;
        return;
      end
      req = req & ~ack;
      if (t == midPulse) begin
        blankStart  = 1'b1;
        blankLength = 12'd4000;
      end else begin
        blankStart  = 1'b0;
      end
      if (t != lineEnd) begin
        @(posedge pixelClock); #1;
      end
    end
    blankStart = 1'b0;
  endtask

  task automatic test_reset;
    logic [9:0] got;
    resetN = 1'b0; blankStart = 1'b0; blankLength = 12'd300; req = 3'b111;
    repeat (3) @(posedge pixelClock);
    #1;
    got = {grant, ack, isFirstPacketClock, dataIslandActive, phase};
    vectors++;
    if (got !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_values: got %b, want 0000000000", got);
    end
    @(negedge pixelClock) resetN = 1'b1;
    @(posedge pixelClock); #1;
    got = {grant, ack, isFirstPacketClock, dataIslandActive, phase};
    vectors++;
    if (got !== 10'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b, want 0000000000", got);
    end
    req = 3'b000;
  endtask

  task automatic test_single_packet;
    run_line(12'd150, 3'b001, 0, 0);
  endtask

  task automatic test_too_short;
    run_line(12'd85, 3'b111, 0, 0);
    req = 3'b000;
    run_line(12'd150, 3'b000, 0, 0);
  endtask

  task automatic test_thresholds;
    run_line(12'd86, 3'b001, 0, 0);
    run_line(12'd87, 3'b000, 0, 0);
    req = 3'b000;
    run_line(12'd120, 3'b101, 0, 0);
  endtask

  task automatic test_max_packets;
    run_line(12'd300, 3'b111, 70, 0);
  endtask

  task automatic test_budget;
    req = 3'b000;
    run_line(12'd119, 3'b011, 0, 0);
    run_line(12'd150, 3'b000, 0, 0);
  endtask

  task automatic test_fixed_priority;
    req = 3'b000;
    for (int i = 0; i < 3; i++) run_line(12'd100, 3'b110, 0, 0);
    req = 3'b000;
  endtask

  task automatic test_reset_mid_island;
    req = 3'b000;
    run_line(12'd150, 3'b001, 0, LEAD + 20);
    run_line(12'd150, 3'b000, 0, 0);
  endtask

  task automatic test_back_to_back;
    req = 3'b000;
    run_line(12'd200, 3'b111, 0, 0);
    run_line(12'd200, 3'b010, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      run_line(12'(60 + $urandom_range(0, 340)), 3'($urandom),
               ($urandom_range(0, 1) == 1) ? $urandom_range(2, 200) : 0, 0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge pixelClock); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_too_short();
    test_thresholds();
    test_max_packets();
    test_budget();
    test_fixed_priority();
    test_reset_mid_island();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
